// File: rtl/fp_pkg.sv
// Shared FP32 definitions: flag bit positions, canonical quiet NaN, and the
// result-plus-flags record queued by the add result stage.
package fp_pkg;

    // Bit positions inside the 5-bit {NV,OF,UF,NX,Z} flag vector.
    localparam int unsigned FLG_NV = 4;
    localparam int unsigned FLG_OF = 3;
    localparam int unsigned FLG_UF = 2;
    localparam int unsigned FLG_NX = 1;
    localparam int unsigned FLG_Z  = 0;

    localparam logic [31:0] FP32_QNAN = 32'h7FC0_0000;

    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  flags;
    } fp32_res_t;

endpackage

// File: rtl/fp_res_fifo.sv
// Result FIFO for the FP add result stage. Power-of-two depth, pointers wrap
// naturally. A push while full is accepted only when a pop happens the same
// cycle. The head is presented combinationally and reads as zero when empty.
module fp_res_fifo
    import fp_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  fp32_res_t              din,
    output fp32_res_t              dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    fp32_res_t     mem_q [DEPTH];
    logic          do_push, do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = empty ? '0 : mem_q[rd_ptr_q];

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            if (do_push && !do_pop) begin
                count_q <= count_q + CW'(1);
            end else if (do_pop && !do_push) begin
                count_q <= count_q - CW'(1);
            end
        end
    end

    // Storage array; contents are don't-care until pushed, so no reset.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/fp_add_result_stage.sv
// FP add result stage: tracks in-flight adder ops, captures each result as it
// leaves the adder pipeline into a small FIFO, accumulates sticky exception
// flags and flags dropped results.
// Optional feature: define FP_ADD_RES_CANON_NAN_EN to replace stored NaN
// results (or any result raising invalid) with the canonical quiet NaN.
module fp_add_result_stage
    import fp_pkg::*;
#(
    parameter int unsigned LATENCY = 3,
    parameter int unsigned DEPTH   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        issue,
    output logic        issue_ok,
    input  logic        Sz,
    input  logic [7:0]  Ez,
    input  logic [22:0] Mz_final,
    input  logic        invalid_flag,
    input  logic        overflow_flag,
    input  logic        underflow_flag,
    input  logic        inexact_flag,
    input  logic        zero_flag,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_data,
    output logic [4:0]  res_flags,
    output logic [3:0]  fflags,
    input  logic        fflags_clr,
    output logic        overrun
);

    logic [LATENCY-1:0]     track_q, track_d;
    logic [4:0]             inflight;
    logic [5:0]             occupancy;
    logic [$clog2(DEPTH):0] fifo_count;
    logic                   fifo_full, fifo_empty;
    logic                   capture, pop, push;
    fp32_res_t              cap, head;
    logic [3:0]             cap_sticky;
    logic [3:0]             fflags_q, fflags_d;
    logic                   overrun_q, overrun_d;

    // Tail of the tracker marks the adder's outputs as valid this cycle.
    assign capture = enable & track_q[LATENCY-1];
    assign pop     = res_valid & res_ready;
    assign push    = capture & (~fifo_full | pop);

    // Tracker shifts only while the adder is enabled.
    always_comb begin
        track_d = track_q;
        if (enable) track_d = LATENCY'({track_q, issue});
    end

    // Ops still inside the adder count against FIFO space.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < int'(LATENCY); i++) begin
            inflight = inflight + 5'(track_q[i]);
        end
        occupancy = 6'(fifo_count) + 6'(inflight);
        issue_ok  = (occupancy < 6'(DEPTH));
    end

    // Assemble the captured record, optionally canonicalising NaNs.
    always_comb begin
        cap.flags         = '0;
        cap.flags[FLG_NV] = invalid_flag;
        cap.flags[FLG_OF] = overflow_flag;
        cap.flags[FLG_UF] = underflow_flag;
        cap.flags[FLG_NX] = inexact_flag;
        cap.flags[FLG_Z]  = zero_flag;
`ifdef FP_ADD_RES_CANON_NAN_EN
        if (invalid_flag || ((Ez == 8'hFF) && (Mz_final != '0))) begin
            cap.data = FP32_QNAN;
        end else begin
            cap.data = {Sz, Ez, Mz_final};
        end
`else
        cap.data = {Sz, Ez, Mz_final};
`endif
        cap_sticky = {cap.flags[FLG_NV], cap.flags[FLG_OF],
                      cap.flags[FLG_UF], cap.flags[FLG_NX]};
    end

    // Sticky flags and overrun; a clear still keeps a same-cycle capture.
    always_comb begin
        fflags_d  = fflags_q;
        overrun_d = overrun_q;
        if (fflags_clr) begin
            fflags_d = capture ? cap_sticky : 4'b0000;
        end else if (capture) begin
            fflags_d = fflags_q | cap_sticky;
        end
        if (capture && fifo_full && !pop) overrun_d = 1'b1;
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            track_q   <= '0;
            fflags_q  <= '0;
            overrun_q <= 1'b0;
        end else begin
            track_q   <= track_d;
            fflags_q  <= fflags_d;
            overrun_q <= overrun_d;
        end
    end

    fp_res_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (cap),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign res_valid = ~fifo_empty;
    assign res_data  = head.data;
    assign res_flags = head.flags;
    assign fflags    = fflags_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_fp_add_result_stage.sv
// Bench for fp_add_result_stage: directed scenarios with literal expectations
// followed by random traffic, all compared every cycle to a queue-based model.
module tb_fp_add_result_stage;

    localparam int unsigned L = 3;
    localparam int unsigned D = 4;

    logic        clk = 1'b0;
    logic        rst, enable, issue, issue_ok;
    logic        Sz;
    logic [7:0]  Ez;
    logic [22:0] Mz_final;
    logic        invalid_flag, overflow_flag, underflow_flag, inexact_flag, zero_flag;
    logic        res_valid, res_ready;
    logic [31:0] res_data;
    logic [4:0]  res_flags;
    logic [3:0]  fflags;
    logic        fflags_clr, overrun;

    int checks   = 0;
    int failures = 0;
    bit started  = 0;

    fp_add_result_stage #(
        .LATENCY (L),
        .DEPTH   (D)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .enable         (enable),
        .issue          (issue),
        .issue_ok       (issue_ok),
        .Sz             (Sz),
        .Ez             (Ez),
        .Mz_final       (Mz_final),
        .invalid_flag   (invalid_flag),
        .overflow_flag  (overflow_flag),
        .underflow_flag (underflow_flag),
        .inexact_flag   (inexact_flag),
        .zero_flag      (zero_flag),
        .res_valid      (res_valid),
        .res_ready      (res_ready),
        .res_data       (res_data),
        .res_flags      (res_flags),
        .fflags         (fflags),
        .fflags_clr     (fflags_clr),
        .overrun        (overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
        end
    endtask

    // Drive the adder outputs; f is {NV,OF,UF,NX,Z}.
    task automatic set_res(input logic [31:0] d, input logic [4:0] f);
        {Sz, Ez, Mz_final} = d;
        {invalid_flag, overflow_flag, underflow_flag, inexact_flag, zero_flag} = f;
    endtask

    // Advance to the middle of the next cycle (outputs settled, inputs free to change).
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    function automatic logic [31:0] model_data(input logic [31:0] raw, input logic inv);
`ifdef FP_ADD_RES_CANON_NAN_EN
        if (inv || (raw[30:23] == 8'hFF && raw[22:0] != 23'd0)) return 32'h7FC0_0000;
        return raw;
`else
        return raw;
`endif
    endfunction

    // ---------------- behavioural model ----------------
    // Each in-flight op carries how many enabled cycles it has spent in the
    // adder; it leaves with the adder outputs on the enabled edge after L of them.
    int          age_q[$];
    logic [36:0] mq[$];
    logic [3:0]  m_fflags;
    bit          m_overrun;
    bit          m_pop, m_cap;
    logic [4:0]  m_f;
    logic [31:0] m_raw;

    always @(posedge clk) begin
        if (rst) begin
            age_q.delete();
            mq.delete();
            m_fflags  = 4'd0;
            m_overrun = 1'b0;
        end else begin
            m_pop = (mq.size() != 0) && res_ready;
            m_cap = 1'b0;
            if (enable) begin
                for (int i = age_q.size() - 1; i >= 0; i--) begin
                    if (age_q[i] == int'(L)) begin
                        age_q.delete(i);
                        m_cap = 1'b1;
                    end
                end
                foreach (age_q[i]) age_q[i] = age_q[i] + 1;
                if (issue) age_q.push_back(1);
            end
            m_f   = {invalid_flag, overflow_flag, underflow_flag, inexact_flag, zero_flag};
            m_raw = {Sz, Ez, Mz_final};
            if (fflags_clr) m_fflags = m_cap ? m_f[4:1] : 4'd0;
            else if (m_cap) m_fflags = m_fflags | m_f[4:1];
            if (m_pop) void'(mq.pop_front());
            if (m_cap) begin
                if (mq.size() < D) mq.push_back({model_data(m_raw, invalid_flag), m_f});
                else m_overrun = 1'b1;
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (started) begin
            chk("m_valid", res_valid, mq.size() != 0);
            if (mq.size() != 0) begin
                chk("m_data", res_data, mq[0][36:5]);
                chk("m_flags", res_flags, mq[0][4:0]);
            end
            chk("m_issue_ok", issue_ok, (mq.size() + age_q.size()) < D);
            chk("m_fflags", fflags, m_fflags);
            chk("m_overrun", overrun, m_overrun);
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1; enable = 1'b1; issue = 1'b0; res_ready = 1'b1; fflags_clr = 1'b0;
        set_res(32'h0, 5'b0);
        tick();
        started = 1;
        chk("rst_valid", res_valid, 0);
        chk("rst_issue_ok", issue_ok, 1);
        chk("rst_data", res_data, 0);
        chk("rst_flags", res_flags, 0);
        chk("rst_fflags", fflags, 0);
        chk("rst_overrun", overrun, 0);
        rst = 1'b0;

        // Single issue: valid exactly L+1 cycles later, then gone after pop.
        set_res(32'h4040_0000, 5'b0);
        issue = 1'b1;
        for (int k = 1; k <= int'(L) + 2; k++) begin
            tick();
            issue = 1'b0;
            chk("a_valid", res_valid, k == int'(L) + 1);
            if (k == int'(L) + 1) begin
                chk("a_data", res_data, 32'h4040_0000);
                chk("a_flags", res_flags, 0);
            end
        end

        // Stall: enable low for two cycles delays the result by two.
        issue = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            tick();
            issue = 1'b0;
            chk("b_valid", res_valid, k == 6);
            if (k == 6) chk("b_data", res_data, 32'h4040_0000);
            enable = !(k == 2 || k == 3);
        end
        enable = 1'b1;

        // Backpressure: 4 results fill the FIFO, a 5th forced one is dropped.
        do_reset();
        for (int c = 0; c <= 12; c++) begin
            if (c == 4) chk("c_issue_ok", issue_ok, 0);
            if (c == 8) chk("c_overrun", overrun, 1);
            if (c >= 8 && c <= 11) begin
                chk("c_valid", res_valid, 1);
                chk("c_data", res_data, 32'h1000_0003 + 32'(c - 8));
            end
            if (c == 12) chk("c_empty", res_valid, 0);
            issue     = (c <= 4);
            res_ready = (c >= 8);
            set_res(32'h1000_0000 + 32'(c), 5'b0);
            tick();
        end
        issue = 1'b0;

        // Sticky flags and clear-vs-capture priority.
        do_reset();
        res_ready = 1'b1;
        for (int c = 0; c <= 10; c++) begin
            if (c == 4) chk("d_res_flags", res_flags, 5'b01000);
            if (c == 6) chk("d_fflags_or", fflags, 4'b0101);
            if (c == 10) chk("d_fflags_clr", fflags, 4'b1000);
            issue      = (c == 0 || c == 1 || c == 6);
            fflags_clr = (c == 9);
            set_res(32'h3F80_0000, c == 3 ? 5'b01000 : c == 4 ? 5'b00010 :
                                   c == 9 ? 5'b10000 : 5'b00000);
            tick();
        end
        issue = 1'b0; fflags_clr = 1'b0;

        // NaN result with invalid raised.
        for (int c = 0; c <= 4; c++) begin
            if (c == 4) begin
                chk("e_valid", res_valid, 1);
`ifdef FP_ADD_RES_CANON_NAN_EN
                chk("e_data", res_data, 32'h7FC0_0000);
`else
                chk("e_data", res_data, 32'hFFC0_0001);
`endif
                chk("e_flags", res_flags, 5'b10000);
            end
            issue = (c == 0);
            set_res(c == 3 ? 32'hFFC0_0001 : 32'h0, c == 3 ? 5'b10000 : 5'b0);
            tick();
        end
        issue = 1'b0;
        set_res(32'h0, 5'b0);

        // Reset with two ops in flight and one queued.
        do_reset();
        res_ready = 1'b0;
        for (int c = 0; c <= 9; c++) begin
            if (c == 4) chk("f_pre_valid", res_valid, 1);
            if (c >= 5) begin
                chk("f_valid", res_valid, 0);
                chk("f_issue_ok", issue_ok, 1);
            end
            issue = (c <= 2);
            rst   = (c == 4);
            set_res(32'h4000_0000, 5'b0);
            tick();
        end
        rst = 1'b0;
        issue = 1'b0;

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            enable     = ($urandom_range(0, 9) < 8);
            issue      = $urandom_range(0, 1);
            res_ready  = ($urandom_range(0, 9) < 6);
            fflags_clr = ($urandom_range(0, 19) == 0);
            rst        = ($urandom_range(0, 199) == 0);
            Sz         = $urandom_range(0, 1);
            Ez         = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
            Mz_final   = ($urandom_range(0, 3) == 0) ? 23'd0 : 23'($urandom);
            {invalid_flag, overflow_flag, underflow_flag, inexact_flag, zero_flag} =
                {$urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 7) == 0};
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
